// File: rtl/washer_pkg.sv
// State encoding shared by the washing-machine controller and its plant emulator,
// so that both ends of the loop decode the 3-bit state bus the same way.
package washer_pkg;

    typedef logic [2:0] state_t;

    localparam state_t IDLE  = 3'd0;
    localparam state_t READY = 3'd1;
    localparam state_t FILL  = 3'd2;
    localparam state_t HEAT  = 3'd3;
    localparam state_t WASH  = 3'd4;
    localparam state_t RINSE = 3'd5;
    localparam state_t SPIN  = 3'd6;
    localparam state_t DRAIN = 3'd7;

    // States in which the drum motor is running.
    function automatic logic is_motor_phase(input state_t s);
        return (s == WASH) || (s == RINSE) || (s == SPIN);
    endfunction

    // States that the per-state watchdog supervises.
    function automatic logic is_supervised(input state_t s);
        return (s != IDLE) && (s != READY);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up/down counter that saturates at 0 and at a programmable upper limit.
// clr wins over inc, and inc wins over dec.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         inc,
    input  logic         dec,
    input  logic         clr,
    input  logic [W-1:0] limit,
    output logic [W-1:0] count
);

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples its inputs from the same pre-edge values.
    always_ff @(posedge clock) begin
        if (reset || clr) begin
            count <= '0;
        end else if (inc) begin
            if (count < limit) begin
                count <= count + W'(1);
            end
        end else if (dec) begin
            if (count != '0) begin
                count <= count - W'(1);
            end
        end
    end

endmodule

// File: rtl/washer_plant_emulator.sv
// Plant model closing the loop around the washer controller: turns the controller's
// state code into water level, temperature, phase-done, watchdog and fault signals.
module washer_plant_emulator
    import washer_pkg::*;
#(
    parameter int CNT_W          = 8,
    parameter int FILL_CYCLES    = 16,
    parameter int HEAT_CYCLES    = 12,
    parameter int WASH_CYCLES    = 32,
    parameter int RINSE_CYCLES   = 24,
    parameter int SPIN_CYCLES    = 20,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [2:0]       state,
    input  logic             fault_unbalance,
    input  logic             fault_motor,
    output logic             sig_Full,
    output logic             sig_Temperature,
    output logic             sig_Completed,
    output logic             sig_Time_Out,
    output logic             sig_Out_Of_Balance,
    output logic             sig_Motor_Failure,
    output logic [CNT_W-1:0] level
);

    localparam logic [CNT_W-1:0] FULL_LEVEL   = CNT_W'(FILL_CYCLES);
    localparam logic [CNT_W-1:0] HOT_TEMP     = CNT_W'(HEAT_CYCLES);
    localparam logic [CNT_W-1:0] WASH_LAST    = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RINSE_LAST   = CNT_W'(RINSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST    = CNT_W'(SPIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX      = '1;

    state_t           state_q;
    logic             entry;
    logic [CNT_W-1:0] phase_cnt;
    logic [CNT_W-1:0] temp;
    logic [CNT_W-1:0] phase_last;
    logic             timed_phase;
    logic             phase_hit;
    logic             drain_hit;
    logic             complete_hit;
    logic             timeout_hit;
    logic             done;

    // A state change seen on the bus this edge restarts every per-visit mechanism.
    assign entry = (state != state_q);

    sat_counter #(.W(CNT_W)) u_phase_cnt (
        .clock (clock),
        .reset (reset),
        .inc   (1'b1),
        .dec   (1'b0),
        .clr   (entry),
        .limit (CNT_MAX),
        .count (phase_cnt)
    );

    sat_counter #(.W(CNT_W)) u_level (
        .clock (clock),
        .reset (reset),
        .inc   (state_q == FILL),
        .dec   (state_q == DRAIN),
        .clr   (1'b0),
        .limit (FULL_LEVEL),
        .count (level)
    );

    sat_counter #(.W(CNT_W)) u_temp (
        .clock (clock),
        .reset (reset),
        .inc   (state_q == HEAT),
        .dec   (1'b0),
        .clr   (state_q == IDLE),
        .limit (HOT_TEMP),
        .count (temp)
    );

    // NOTE: every always_comb output gets a default before the case so that no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        timed_phase = 1'b0;
        phase_last  = '0;
        case (state_q)
            WASH: begin
                timed_phase = 1'b1;
                phase_last  = WASH_LAST;
            end
            RINSE: begin
                timed_phase = 1'b1;
                phase_last  = RINSE_LAST;
            end
            SPIN: begin
                timed_phase = 1'b1;
                phase_last  = SPIN_LAST;
            end
            default: begin
                timed_phase = 1'b0;
                phase_last  = '0;
            end
        endcase
    end

    assign phase_hit    = timed_phase && (phase_cnt == phase_last);
    // Level reaches zero on this edge: it is already 0 or is about to step down from 1.
    assign drain_hit    = (state_q == DRAIN) && (level <= CNT_W'(1));
    assign complete_hit = !entry && !done && (phase_hit || drain_hit);
    assign timeout_hit  = is_supervised(state_q) && (phase_cnt == TIMEOUT_LAST);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q            <= IDLE;
            done               <= 1'b0;
            sig_Full           <= 1'b0;
            sig_Temperature    <= 1'b0;
            sig_Completed      <= 1'b0;
            sig_Time_Out       <= 1'b0;
            sig_Out_Of_Balance <= 1'b0;
            sig_Motor_Failure  <= 1'b0;
        end else begin
            state_q         <= state;
            sig_Full        <= (level == FULL_LEVEL);
            sig_Temperature <= (temp == HOT_TEMP);
            sig_Completed   <= complete_hit;

            if (entry) begin
                done               <= 1'b0;
                sig_Time_Out       <= 1'b0;
                sig_Out_Of_Balance <= 1'b0;
            end else begin
                if (complete_hit) begin
                    done <= 1'b1;
                end
                if (timeout_hit) begin
                    sig_Time_Out <= 1'b1;
                end
                if ((state_q == SPIN) && fault_unbalance) begin
                    sig_Out_Of_Balance <= 1'b1;
                end
            end

            // Motor failure survives state changes; only a return to IDLE clears it.
            if (state_q == IDLE) begin
                sig_Motor_Failure <= 1'b0;
            end else if (!entry && is_motor_phase(state_q) && fault_motor) begin
                sig_Motor_Failure <= 1'b1;
            end
        end
    end

endmodule
